// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS EX-stage types and funct constants
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mul_state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;

endpackage

// File: rtl/multu_shift_add.sv
// rtl/multu_shift_add.sv - shift-add datapath: multiplicand, multiplier and running product
module multu_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Multiplier once this step's shift is applied is zero: no set bits remain.
  assign mplier_zero = ~|mplier[WIDTH-1:1];

  // Load operands on issue, then one partial product per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// rtl/multu_hilo_unit.sv - MULTU sequencer and HI/LO registers; MULTU_EARLY_TERM_EN enables early exit
module multu_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_t         state, state_n;
  logic [CW-1:0]      cnt;
  logic               load, step, last_iter;
  logic               mplier_zero;
  logic [2*WIDTH-1:0] prod;

  multu_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .a           (a),
    .b           (b),
    .prod        (prod),
    .mplier_zero (mplier_zero)
  );

`ifdef MULTU_EARLY_TERM_EN
  assign last_iter = (cnt == CNT_LAST) || mplier_zero;
`else
  logic unused_mplier_zero;
  assign unused_mplier_zero = mplier_zero;
  assign last_iter = (cnt == CNT_LAST);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and datapath controls; new starts are only accepted in IDLE.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_iter) state_n = FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Iteration counter, cleared on issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CW'(1);
  end

  // HI/LO: the product commits on leaving FINISH; mthi/mtlo only land while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        {hi, lo} <= prod;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb/tb_multu_hilo_unit.sv - self-checking bench for multu_hilo_unit
module tb_multu_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             hi_we = 1'b0;
  logic             lo_we = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;

  multu_hilo_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles spent in RUN for multiplier value ib.
  function automatic int run_len(input logic [WIDTH-1:0] ib);
    int n;
    n = WIDTH;
`ifdef MULTU_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (ib[i]) n = i + 1;
`endif
    return n;
  endfunction

  // Issue one MULTU, optionally disturbing it at cycle poke_at after issue.
  // poke_kind: 0 none, 1 extra start, 2 mthi, 3 mthi+mtlo. with_we writes 55AA at issue.
  task automatic do_mul(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                        input int poke_at, input int poke_kind, input bit with_we,
                        input string nm);
    int k, bcnt, iters;
    bit seen, held;
    iters = run_len(ib);
    a = ia; b = ib; start = 1'b1;
    if (with_we) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA;
      m_hi = 32'h55AA; m_lo = 32'h55AA;
    end
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    k = 0; bcnt = 0; seen = 1'b0; held = 1'b1;
    while (k <= 3 * WIDTH) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      if (k == poke_at) begin
        case (poke_kind)
          1: begin start = 1'b1; a = 32'd2; b = 32'd2; end
          2: begin hi_we = 1'b1; wdata = 32'hDEAD; end
          3: begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF; end
          default: ;
        endcase
      end
      tick();
      k++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_latency"}, 64'(k), 64'(iters + 1));
    check({nm, "_busy_cycles"}, 64'(bcnt), 64'(iters));
    check({nm, "_hold_old"}, 64'(held), 64'd1);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
    tick();
    check({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({nm, "_idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic idle_write(input bit hw, input bit lw, input logic [WIDTH-1:0] d, input string nm);
    hi_we = hw; lo_we = lw; wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    check({nm, "_hi"}, 64'(hi), 64'(m_hi));
    check({nm, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [63:0] p;
    bit seen;

    vecs[0] = '{32'd3,          32'd5,          32'h0,        32'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{32'd0,          32'd12345,      32'h0,        32'h0};
    vecs[3] = '{32'd1,          32'hFFFFFFFF,   32'h0,        32'hFFFFFFFF};
    vecs[4] = '{32'h80000000,   32'd2,          32'h1,        32'h0};
    vecs[5] = '{32'h00010000,   32'h00010000,   32'h1,        32'h0};
    vecs[6] = '{32'd7,          32'd1,          32'h0,        32'd7};
    vecs[7] = '{32'd7,          32'h80000000,   32'h3,        32'h80000000};

    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      do_mul(vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, -1, 0, 1'b0, $sformatf("vec%0d", i));

    do_mul(32'd7, 32'd9, 32'h0, 32'd63, 3, 1, 1'b0, "restart_in_run");
    do_mul(32'd11, 32'hFFFFFFFF, 32'd10, 32'hFFFFFFF5, 5, 2, 1'b0, "mthi_in_run");
    idle_write(1'b0, 1'b1, 32'h1234, "mtlo_idle");
    idle_write(1'b1, 1'b1, 32'hCAFE, "mthi_mtlo_idle");
    do_mul(32'd6, 32'd7, 32'h0, 32'd42, run_len(32'd7), 3, 1'b0, "we_in_finish");
    do_mul(32'd9, 32'd9, 32'h0, 32'd81, run_len(32'd9), 1, 1'b0, "start_in_finish");
    do_mul(32'd4, 32'd5, 32'h0, 32'd20, -1, 0, 1'b1, "start_with_we");

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      p = {32'd0, ra} * {32'd0, rb};
      if ($urandom_range(0, 1) == 1) idle_write(1'b1, 1'b0, $urandom, $sformatf("rnd_mthi%0d", i));
      do_mul(ra, rb, p[63:32], p[31:0], -1, 0, 1'b0, $sformatf("rnd%0d", i));
    end

    idle_write(1'b1, 1'b1, 32'hA5A5A5A5, "pre_reset");
    a = 32'd3; b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("run10_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (3 * WIDTH) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    check("hi_after_rst", 64'(hi), 64'd0);
    check("lo_after_rst", 64'(lo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
